multicycle_controller: RTL

//  Moore-style FSM that sequences the 16-bit datapath over several cycles so one ALU serves both the PC increment and execute.

---
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/multicycle_controller.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the datapath.
// Carries the instruction-memory handshake, the IR contents and every datapath
// enable/select the controller generates.
//   imem_ready   instruction memory data valid this cycle
//   ir           instruction register contents
//   ir_write     load IR from instruction memory
//   pc_write     load PC from ALU result (PC+2)
//   alu_src_a    0 = PC, 1 = register-file RD1
//   alu_src_b    00 = RD2, 01 = constant 2, 10 = sign-extended ir[7:0]
//   alu_control  ALU op code
//   reg_dst      0 = ir[9:8], 1 = ir[7:6] as write register
//   reg_write    register-file write enable
// master: the controller. slave: the datapath / instruction memory side.
interface multicycle_controller_if;
    logic        imem_ready;
    logic [15:0] ir;
    logic        ir_write;
    logic        pc_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic        reg_dst;
    logic        reg_write;

    modport master (
        input  imem_ready, ir,
        output ir_write, pc_write, alu_src_a, alu_src_b, alu_control, reg_dst, reg_write
    );

    modport slave (
        output imem_ready, ir,
        input  ir_write, pc_write, alu_src_a, alu_src_b, alu_control, reg_dst, reg_write
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style sequencer for a 16-bit multicycle datapath: one ALU serves both the
// PC increment (FETCH) and instruction execution (EXECUTE). Stalls in FETCH until
// instruction memory is ready, halts on HALT_WORD and counts retired instructions.
// Ports:
//   clock        system clock, state updates on posedge
//   reset        synchronous, active-high, dominant over all other inputs
//   bus          control bus (master side), see multicycle_controller_if
//   halted       high while in HALT
//   instr_count  retired-instruction counter, wraps silently
module multicycle_controller #(
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    multicycle_controller_if.master  bus,
    output logic                     halted,
    output logic [COUNT_W-1:0]       instr_count
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);

    state_e               state;
    logic                 alu_src_a_q;
    logic [1:0]           alu_src_b_q;
    logic [3:0]           alu_control_q;
    logic                 reg_dst_q;
    logic                 reg_write_q;
    logic                 halted_q;
    logic [COUNT_W-1:0]   count_q;

    logic [3:0]           opcode;
    logic                 op_legal;
    logic [3:0]           dec_control;
    logic [1:0]           dec_src_b;

    assign opcode   = bus.ir[15:12];
    assign op_legal = ~opcode[3];

    always_comb begin
        dec_control = 4'b0010;
        dec_src_b   = 2'b00;
        case (opcode)
            4'b0000: dec_control = 4'b0010;  // add
            4'b0001: dec_control = 4'b0110;  // sub
            4'b0010: dec_control = 4'b0000;  // and
            4'b0011: dec_control = 4'b0001;  // or
            4'b0100: dec_control = 4'b1100;  // nor
            4'b0101: dec_control = 4'b1101;  // nand
            4'b0110: dec_control = 4'b0111;  // slt
            4'b0111: begin                   // addi
                dec_control = 4'b0010;
                dec_src_b   = 2'b10;
            end
            default: ;
        endcase
    end

    // Registered outputs are loaded with the values belonging to the state being
    // entered, so they are valid for the whole cycle spent in that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= StFetch;
            alu_src_a_q   <= 1'b0;
            alu_src_b_q   <= 2'b01;
            alu_control_q <= 4'b0010;
            reg_dst_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            halted_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            case (state)
                StFetch: begin
                    if (bus.imem_ready) begin
                        state <= StDecode;
                    end
                end
                StDecode: begin
                    if (bus.ir == HALT_WORD) begin
                        state    <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
                        state         <= StExecute;
                        alu_src_a_q   <= 1'b1;
                        alu_src_b_q   <= dec_src_b;
                        alu_control_q <= dec_control;
                    end
                end
                StExecute: begin
                    if (op_legal) begin
                        state       <= StWriteback;
                        reg_write_q <= 1'b1;
                        reg_dst_q   <= (opcode != 4'b0111);
                    end else begin
                        // Illegal opcode retires as a NOP without a register write.
                        state         <= StFetch;
                        alu_src_a_q   <= 1'b0;
                        alu_src_b_q   <= 2'b01;
                        alu_control_q <= 4'b0010;
                        count_q       <= count_q + CountOne;
                    end
                end
                StWriteback: begin
                    state         <= StFetch;
                    alu_src_a_q   <= 1'b0;
                    alu_src_b_q   <= 2'b01;
                    alu_control_q <= 4'b0010;
                    reg_dst_q     <= 1'b0;
                    reg_write_q   <= 1'b0;
                    count_q       <= count_q + CountOne;
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state <= StFetch;
                end
            endcase
        end
    end

    // Fetch strobes follow imem_ready directly; reset masks them and any pending
    // writeback so an aborted instruction never writes.
    assign bus.ir_write    = (state == StFetch) & bus.imem_ready & ~reset;
    assign bus.pc_write    = (state == StFetch) & bus.imem_ready & ~reset;
    assign bus.reg_write   = reg_write_q & ~reset;
    assign bus.alu_src_a   = alu_src_a_q;
    assign bus.alu_src_b   = alu_src_b_q;
    assign bus.alu_control = alu_control_q;
    assign bus.reg_dst     = reg_dst_q;
    assign halted          = halted_q;
    assign instr_count     = count_q;

endmodule
